// File: rtl/tiny16_pkg.sv
// rtl/tiny16_pkg.sv - shared types and default constants for the tiny16 register file
//
// Purpose: stack-op encoding and the default geometry / special-register
//          indices used by regfile_param and anything that instantiates it.
// Ports:   none (package).
package tiny16_pkg;

   localparam int          DATA_W   = 16;
   localparam int          ADDR_W   = 3;
   localparam int          PC_IDX   = 0;
   localparam int          SP_IDX   = 1;
   localparam logic [15:0] SP_RESET = 16'h00FF;

   typedef enum logic [1:0] {
      SP_NONE = 2'b00,
      SP_PUSH = 2'b01,
      SP_POP  = 2'b10,
      SP_RSVD = 2'b11
   } sp_op_t;

endpackage

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with PC/SP update paths and write-first reads
//
// Purpose: 2**ADDR_W x DATA_W register bank between decoder/ALU and the
//          internal bus. Each edge builds the complete next state of every
//          register, commits it, and reads src/dst/out from that next state.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   src_sel   in   source register select
//   dst_sel   in   destination register select (read and write)
//   in_en     in   write `in` to gpr[dst_sel]
//   in        in   write data
//   out_en    in   gate the selected source onto `out`
//   pc_inc    in   PC += 1
//   sp_op     in   00 none, 01 push (SP-1), 10 pop (SP+1), 11 no-op
//   out       out  registered gated bus output
//   src       out  registered source operand
//   dst       out  registered destination operand
//   sp_fault  out  sticky stack overflow/underflow flag
module regfile_param #(
   parameter int                DATA_W   = tiny16_pkg::DATA_W,
   parameter int                ADDR_W   = tiny16_pkg::ADDR_W,
   parameter int                PC_IDX   = tiny16_pkg::PC_IDX,
   parameter int                SP_IDX   = tiny16_pkg::SP_IDX,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(tiny16_pkg::SP_RESET)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] src_sel,
   input  logic [ADDR_W-1:0] dst_sel,
   input  logic              in_en,
   input  logic [DATA_W-1:0] in,
   input  logic              out_en,
   input  logic              pc_inc,
   input  logic [1:0]        sp_op,
   output logic [DATA_W-1:0] out,
   output logic [DATA_W-1:0] src,
   output logic [DATA_W-1:0] dst,
   output logic              sp_fault
);

   import tiny16_pkg::*;

   localparam int NREG = 2 ** ADDR_W;

   if (PC_IDX == SP_IDX || PC_IDX < 0 || SP_IDX < 0 ||
       PC_IDX >= NREG || SP_IDX >= NREG) begin : g_bad_idx
      $error("regfile_param: PC_IDX/SP_IDX must be distinct and below 2**ADDR_W");
   end

   logic [DATA_W-1:0] gpr [NREG];
   logic [DATA_W-1:0] nxt [NREG];
   logic              fault_set;
   sp_op_t            op;

   assign op = sp_op_t'(sp_op);

   // Later assignments win: PC/SP arithmetic first, then an explicit write
   // to the same index overrides it.
   always_comb begin
      nxt       = gpr;
      fault_set = 1'b0;

      if (pc_inc) begin
         nxt[PC_IDX] = gpr[PC_IDX] + DATA_W'(1);
      end

      case (op)
         SP_PUSH: begin
            nxt[SP_IDX] = gpr[SP_IDX] - DATA_W'(1);
            fault_set   = (gpr[SP_IDX] == '0);
         end
         SP_POP: begin
            nxt[SP_IDX] = gpr[SP_IDX] + DATA_W'(1);
            fault_set   = (gpr[SP_IDX] == SP_RESET);
         end
         default: ;
      endcase

      if (in_en) begin
         nxt[dst_sel] = in;
         // A write to SP pre-empts the stack op, so that op cannot fault.
         if (int'(dst_sel) == SP_IDX) begin
            fault_set = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            gpr[i] <= (i == SP_IDX) ? SP_RESET : '0;
         end
         src      <= '0;
         dst      <= '0;
         out      <= '0;
         sp_fault <= 1'b0;
      end else begin
         gpr      <= nxt;
         src      <= nxt[src_sel];
         dst      <= nxt[dst_sel];
         out      <= out_en ? nxt[src_sel] : '0;
         sp_fault <= sp_fault | fault_set;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param
module tb_regfile_param;

   logic        clk;
   logic        rst_n;
   logic [2:0]  src_sel;
   logic [2:0]  dst_sel;
   logic        in_en;
   logic [15:0] d_in;
   logic        out_en;
   logic        pc_inc;
   logic [1:0]  sp_op;
   logic [15:0] d_out;
   logic [15:0] src;
   logic [15:0] dst;
   logic        sp_fault;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: plain integers, reduced modulo 2**16 after each op.
   int m_reg [8];
   bit m_fault;

   regfile_param dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_sel  (src_sel),
      .dst_sel  (dst_sel),
      .in_en    (in_en),
      .in       (d_in),
      .out_en   (out_en),
      .pc_inc   (pc_inc),
      .sp_op    (sp_op),
      .out      (d_out),
      .src      (src),
      .dst      (dst),
      .sp_fault (sp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_reg[1] = 255;
      m_fault  = 0;
   endtask

   task automatic check_all(input string tag, input int e_src, input int e_dst,
                            input int e_out, input bit e_flt);
      check({tag, ".src"}, src, 16'(e_src));
      check({tag, ".dst"}, dst, 16'(e_dst));
      check({tag, ".out"}, d_out, 16'(e_out));
      check({tag, ".fault"}, {15'd0, sp_fault}, {15'd0, e_flt});
   endtask

   // One clocked operation: drive at negedge, update model, check after posedge.
   task automatic step(input string tag, input int s, input int d, input bit we,
                       input int wd, input bit oe, input bit pi, input int so);
      int nr [8];
      bit flt;
      @(negedge clk);
      src_sel = 3'(s); dst_sel = 3'(d); in_en = we; d_in = 16'(wd);
      out_en = oe; pc_inc = pi; sp_op = 2'(so);
      nr  = m_reg;
      flt = 0;
      if (pi) nr[0] = (m_reg[0] + 1) % 65536;
      if (so == 1) begin
         nr[1] = (m_reg[1] + 65535) % 65536;
         if (m_reg[1] == 0) flt = 1;
      end else if (so == 2) begin
         nr[1] = (m_reg[1] + 1) % 65536;
         if (m_reg[1] == 255) flt = 1;
      end
      if (we) begin
         nr[d] = wd % 65536;
         if (d == 1) flt = 0;
      end
      m_reg   = nr;
      m_fault = m_fault | flt;
      @(posedge clk);
      #1;
      check_all(tag, m_reg[s], m_reg[d], oe ? m_reg[s] : 0, m_fault);
      @(negedge clk);
      in_en = 0; pc_inc = 0; sp_op = 0; out_en = 0;
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; src_sel = 0; dst_sel = 0; in_en = 0; d_in = 0;
      out_en = 0; pc_inc = 0; sp_op = 0;
      model_reset();
      #12;
      check_all("reset", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      step("read_sp", 1, 2, 0, 0, 1, 0, 0);
      check("read_sp.lit", d_out, 16'h00FF);
      step("bypass", 3, 3, 1, 'hBEEF, 1, 0, 0);
      check("bypass.lit", src, 16'hBEEF);

      step("pc_set", 0, 0, 1, 'hFFFF, 1, 0, 0);
      step("pc_wrap", 0, 4, 1, 'h1234, 1, 1, 0);
      check("pc_wrap.lit", src, 16'h0000);
      step("pc_wprio", 0, 0, 1, 'h0100, 1, 1, 0);
      check("pc_wprio.lit", src, 16'h0100);
      step("pc_sp_ind", 0, 1, 0, 0, 1, 1, 1);

      pulse_reset("rst1");
      step("pop_empty", 1, 1, 0, 0, 1, 0, 2);
      check("pop_empty.lit", src, 16'h0100);
      check("pop_empty.flt", {15'd0, sp_fault}, 16'd1);
      step("push1", 1, 1, 0, 0, 1, 0, 1);
      step("push2", 1, 1, 0, 0, 1, 0, 1);

      pulse_reset("rst2");
      step("sp_zero", 1, 1, 1, 0, 1, 0, 0);
      step("push_zero", 1, 1, 0, 0, 1, 0, 1);
      check("push_zero.lit", src, 16'hFFFF);
      step("sp_rsvd", 1, 1, 0, 0, 1, 0, 3);
      check("sp_rsvd.lit", src, 16'hFFFF);

      pulse_reset("rst3");
      step("wp_prio", 1, 1, 1, 0, 1, 0, 1);
      check("wp_prio.flt", {15'd0, sp_fault}, 16'd0);

      // Reset lands mid-cycle while a write to r5 is being driven.
      step("pre_r5", 5, 5, 1, 'h5A5A, 1, 0, 0);
      @(negedge clk);
      src_sel = 5; dst_sel = 5; in_en = 1; d_in = 16'hC3C3; out_en = 1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("rst_hold", 0, 0, 0, 0);
      @(negedge clk);
      in_en = 0; rst_n = 1'b1;
      step("r5_lost", 5, 5, 0, 0, 1, 0, 0);

      for (int k = 0; k < 300; k++) begin
         if (k % 60 == 59) pulse_reset("rrst");
         step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 65535)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the tiny16 general-purpose register bank: a register file of configurable width and depth with registered source/destination read ports, a gated bus output, a write port, and dedicated program-counter and stack-pointer update paths. It sits between the decoder/ALU and the internal data bus. It adds write-first read bypass, push/pop stack-pointer arithmetic with a sticky stack-fault flag, and defined priority between simultaneous updates.

## Interface
Parameters:
- DATA_W, 16, register and bus width
- ADDR_W, 3, select width; the file holds 2**ADDR_W registers
- PC_IDX, 0, index of the program counter
- SP_IDX, 1, index of the stack pointer; must differ from PC_IDX
- SP_RESET, 'h00FF, stack pointer reset value (empty-stack position)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_sel  in  ADDR_W  source register select
- dst_sel  in  ADDR_W  destination register select (read and write)
- in_en  in  1  write `in` to gpr[dst_sel]
- in  in  DATA_W  write data
- out_en  in  1  drive the selected source onto `out`
- pc_inc  in  1  PC += 1
- sp_op  in  2  stack op: 00 none, 01 push (SP -= 1), 10 pop (SP += 1), 11 reserved (no-op)
- out  out  DATA_W  registered bus output
- src  out  DATA_W  registered source operand
- dst  out  DATA_W  registered destination operand
- sp_fault  out  1  sticky stack overflow/underflow flag

## Operation
- Reset (rst_n low, asynchronous): all registers 0 except gpr[SP_IDX] = SP_RESET; src, dst, and out = 0; sp_fault = 0. Reset is held while rst_n is low, and any in-flight update is discarded.
- Each edge computes next-state nxt[i] for every register, then commits it.
- Priority per register:
  - An in_en write to that index beats the pc_inc or sp_op update to the same index.
  - Otherwise PC takes PC+1 when pc_inc is high.
  - SP takes SP-1 on push and SP+1 on pop.
- pc_inc and sp_op act independently in the same cycle. A write to a third register does not block them.
- Arithmetic is modulo 2**DATA_W: PC all-ones + 1 gives 0.
- Reads are write-first:
  - src ← nxt[src_sel] and dst ← nxt[dst_sel], i.e. the value the register holds after this edge, including in/pc/sp updates.
  - out ← nxt[src_sel] when out_en is high, otherwise 0.
- Stack fault:
  - Set on a push while SP == 0.
  - Set on a pop while SP == SP_RESET.
  - The SP update still occurs, with wrap on push.
  - Not set if an in_en write to SP takes priority that cycle.
  - Cleared only by reset.
- sp_op = 11 changes nothing and raises no fault.

## Timing
- All outputs are registered. Read latency is 1 cycle from the select inputs to src, dst, and out.
- Write-to-read latency is 0 extra cycles: with in_en, the same-index read shows `in` on the following edge's outputs.
- The back-to-back write then read of the same register needs no stall.
- sp_fault asserts on the edge that performs the faulting op.
- Reset deassertion is synchronised externally. The first update happens on the first rising edge with rst_n high.

## Structure
- Shared package tiny16_pkg:
  - sp_op_t enum (SP_NONE, SP_PUSH, SP_POP, SP_RSVD)
  - default DATA_W and ADDR_W
  - PC_IDX, SP_IDX, and SP_RESET constants
- Single module, no sub-module: one combinational next-state block plus one clocked always block.
- An elaboration-time check rejects PC_IDX == SP_IDX and any index ≥ 2**ADDR_W.

## Test plan
- Reset → src = dst = out = 0 and sp_fault = 0. Reading SP_IDX with out_en shows 'h00FF; reading r2 shows 0.
- in_en=1, dst_sel=3, in='hBEEF, src_sel=3, out_en=1 → after 1 edge src = dst = out = 'hBEEF (bypass).
- PC = 'hFFFF, pc_inc=1, plus an in_en write to r4 → PC = 0 and r4 is written. Then pc_inc=1 together with in_en to PC with 'h0100 → PC = 'h0100.
- From reset, pop → SP = 'h0100 and sp_fault = 1. Further pushes leave sp_fault at 1 until rst_n pulses low.
- Write SP = 0, then push → SP = 'hFFFF and sp_fault = 1. sp_op = 11 → SP unchanged.
- Assert rst_n low mid-cycle during a write → outputs go to 0 immediately with no edge needed, and the write is lost.
